// File: rtl/ifu_fetch.sv
// Instruction fetch sequencer: one outstanding imem read per instruction,
// with a valid/ready hand-off to decode and flush/redirect support.
module ifu_fetch #(
  parameter int WIDTH       = 32,
  parameter int ILEN        = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_wen,
  input  logic             flush,
  output logic             req_valid,
  output logic [WIDTH-1:0] req_addr,
  input  logic             req_ready,
  input  logic             rsp_valid,
  input  logic [ILEN-1:0]  rsp_data,
  input  logic             rsp_err,
  output logic             inst_valid,
  output logic [ILEN-1:0]  inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_fault,
  output logic             inst_cause,
  input  logic             inst_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [ILEN-1:0]  inst_q, inst_d;
  logic             fault_q, fault_d;
  logic             cause_q, cause_d;
  logic             misaligned;

  assign misaligned = CHECK_ALIGN && (pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      inst_pc_q  <= '0;
      inst_q     <= '0;
      fault_q    <= 1'b0;
      cause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      inst_pc_q  <= inst_pc_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    inst_pc_d  = inst_pc_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          req_addr_d = pc;
          inst_pc_d  = pc;
          if (misaligned) begin
            inst_d  = '0;
            fault_d = 1'b1;
            cause_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // An accepted request still owes a response, so a flush must drain it.
        if (flush)          state_d = req_ready ? DRAIN : IDLE;
        else if (req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_d = rsp_valid ? IDLE : DRAIN;
        end else if (rsp_valid) begin
          inst_d  = rsp_data;
          fault_d = rsp_err;
          cause_d = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush || inst_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_valid  = (state_q == REQ);
  assign inst_valid = (state_q == HOLD);
  assign pc_wen     = (state_q == HOLD) && inst_ready && !flush;
  assign req_addr   = req_addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;
  assign inst_cause = cause_q;

endmodule
